// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard unit. Handles memory-wait stalls, EX redirects,
//            load-use stalls, operand forwarding and the stall-cycle counter.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [6:0]       id_types,
    input  logic             id_valid_inst,
    input  logic             ex_redirect,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_access;
        logic       mem_read;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_stage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_access;
    } mem_stage_t;

    // No WB-stage decision depends on mem_access, so WB keeps only what forwarding reads.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } wb_stage_t;

    // Type bits R,I,S,B,U,J,Z sit at 6..0
    localparam logic [6:0]       C_RS1_TYPES = 7'b1111000;
    localparam logic [6:0]       C_RS2_TYPES = 7'b1011000;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    ex_stage_t  ex_s;
    ex_stage_t  ex_next;
    mem_stage_t mem_s;
    wb_stage_t  wb_s;
    logic       illegal_q;

    logic use_rs1;
    logic use_rs2;
    logic mem_stall;
    logic lduse;
    logic advance;
    logic stall_event;

    assign use_rs1   = |(id_types & C_RS1_TYPES);
    assign use_rs2   = |(id_types & C_RS2_TYPES);
    assign mem_stall = mem_s.valid & mem_s.mem_access & ~dmem_ready;
    assign lduse     = id_valid & ex_s.valid & ex_s.mem_read & (ex_s.rd != 5'd0) &
                       ((use_rs1 & (ex_s.rd == id_rs1_addr)) |
                        (use_rs2 & (ex_s.rd == id_rs2_addr)));
    assign advance     = ~mem_stall & ~ex_redirect & ~lduse;
    assign stall_event = mem_stall | (lduse & ~ex_redirect);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lduse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Illegal or absent instructions enter EX as an all-zero bubble.
    always_comb begin
        ex_next = '0;
        if (advance & id_valid & id_valid_inst) begin
            ex_next.valid      = 1'b1;
            ex_next.rd         = id_rd_addr;
            ex_next.reg_write  = id_reg_write;
            ex_next.mem_access = id_mem_read | id_mem_write;
            ex_next.mem_read   = id_mem_read;
            ex_next.rs1        = id_rs1_addr;
            ex_next.rs2        = id_rs2_addr;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input mem_stage_t m,
                                           input wb_stage_t w);
        // Loads in MEM have no result yet; the load-use stall covers them.
        if (m.valid & m.reg_write & ~m.mem_access & (m.rd != 5'd0) & (m.rd == rs))
            return 2'b01;
        if (w.valid & w.reg_write & (w.rd != 5'd0) & (w.rd == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    assign fwd_a         = fwd_sel(ex_s.rs1, mem_s, wb_s);
    assign fwd_b         = fwd_sel(ex_s.rs2, mem_s, wb_s);
    assign illegal_instr = illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_s      <= '0;
            mem_s     <= '0;
            wb_s      <= '0;
            illegal_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (stall_event && (stall_cnt != '1))
                stall_cnt <= stall_cnt + C_CNT_ONE;
            illegal_q <= advance & id_valid & ~id_valid_inst;
            if (mem_stall) begin
                wb_s <= '0;
            end else begin
                wb_s  <= '{valid: mem_s.valid, rd: mem_s.rd, reg_write: mem_s.reg_write};
                mem_s <= '{valid: ex_s.valid, rd: ex_s.rd, reg_write: ex_s.reg_write,
                           mem_access: ex_s.mem_access};
                ex_s  <= ex_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed scenarios plus randomized traffic for hazard_ctrl,
//            checked against an instruction-level pipeline model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [6:0] T_R = 7'b1000000;
    localparam logic [6:0] T_I = 7'b0100000;
    localparam logic [6:0] T_S = 7'b0010000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic id_valid = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic id_valid_inst = 1'b1, ex_redirect = 1'b0, dmem_ready = 1'b1;
    logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic [6:0] id_types = '0;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic illegal_instr;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_types(id_types), .id_valid_inst(id_valid_inst),
        .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal_instr(illegal_instr), .stall_cnt(stall_cnt)
    );

    // In-flight instruction record; slot 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       rw;
        bit       ma;
        bit       mr;
    } slot_t;

    slot_t pipe [3];
    int    m_cnt;
    bit    m_ill;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mem_stall();
        return pipe[1].v && pipe[1].ma && !dmem_ready;
    endfunction

    function automatic bit m_lduse();
        bit reads1, reads2;
        reads1 = id_types[6] || id_types[5] || id_types[4] || id_types[3];
        reads2 = id_types[6] || id_types[4] || id_types[3];
        return id_valid && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
               ((reads1 && pipe[0].rd == id_rs1_addr) || (reads2 && pipe[0].rd == id_rs2_addr));
    endfunction

    // Nearest older producer wins; a load still in MEM cannot supply data.
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == rs &&
                !(s == 1 && pipe[s].ma))
                return 2'(s);
        end
        return 2'b00;
    endfunction

    task automatic sample();
        logic [6:0] exp_ctrl;
        @(negedge clk);
        if (m_mem_stall())     exp_ctrl = 7'b0000001;
        else if (ex_redirect)  exp_ctrl = 7'b1111110;
        else if (m_lduse())    exp_ctrl = 7'b0001110;
        else                   exp_ctrl = 7'b1101010;
        check("ctrl", 64'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}),
              64'(exp_ctrl));
        check("fwd", 64'({fwd_a, fwd_b}), 64'({m_fwd(pipe[0].rs1), m_fwd(pipe[0].rs2)}));
        check("illegal", 64'(illegal_instr), 64'(m_ill));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    task automatic advance();
        bit ms, lu;
        slot_t nxt;
        ms = m_mem_stall();
        lu = m_lduse();
        @(posedge clk);
        if (reset) begin
            foreach (pipe[i]) pipe[i] = '{default: 0};
            m_cnt = 0;
            m_ill = 0;
        end else begin
            if ((ms || (!ex_redirect && lu)) && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_ill = !ms && !ex_redirect && !lu && id_valid && !id_valid_inst;
            if (ms) begin
                pipe[2] = '{default: 0};
            end else begin
                nxt = '{default: 0};
                if (!ex_redirect && !lu && id_valid && id_valid_inst)
                    nxt = '{v: 1, rd: id_rd_addr, rs1: id_rs1_addr, rs2: id_rs2_addr,
                            rw: id_reg_write, ma: id_mem_read || id_mem_write, mr: id_mem_read};
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = nxt;
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic set_id(input bit v, input logic [6:0] t, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit rw, input bit mr, input bit mw, input bit vi);
        id_valid = v; id_types = t; id_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_valid_inst = vi;
    endtask

    task automatic nop();
        set_id(0, T_R, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; ex_redirect = 1'b0; dmem_ready = 1'b1; nop();
        step();
        reset = 1'b0;
    endtask

    initial begin
        foreach (pipe[i]) pipe[i] = '{default: 0};
        m_cnt = 0;
        m_ill = 0;
        #1;

        // load-use: lw x5 ; add x6,x5,x1
        do_reset();
        sample();
        check("rst_ctrl", 64'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}),
              64'(7'b1101010));
        advance();
        set_id(1, T_I, 5, 2, 0, 1, 1, 0, 1); step();
        set_id(1, T_R, 6, 5, 1, 1, 0, 0, 1);
        sample();
        check("lduse_pc_en", 64'(pc_en), 64'(0));
        check("lduse_idex_flush", 64'(idex_flush), 64'(1));
        advance();
        step();
        nop(); sample();
        check("lduse_fwd_a", 64'(fwd_a), 64'(2'b10));
        check("lduse_cnt", 64'(stall_cnt), 64'(1));
        advance();

        // back-to-back ALU dependency, then with one gap
        do_reset();
        set_id(1, T_R, 3, 1, 2, 1, 0, 0, 1); step();
        set_id(1, T_R, 4, 3, 3, 1, 0, 0, 1); step();
        nop(); sample();
        check("alu_fwd_mem", 64'({fwd_a, fwd_b}), 64'(4'b0101));
        check("alu_no_stall", 64'(pc_en), 64'(1));
        advance();
        do_reset();
        set_id(1, T_R, 3, 1, 2, 1, 0, 0, 1); step();
        set_id(1, T_R, 7, 8, 9, 1, 0, 0, 1); step();
        set_id(1, T_R, 4, 3, 3, 1, 0, 0, 1); step();
        nop(); sample();
        check("alu_fwd_wb", 64'({fwd_a, fwd_b}), 64'(4'b1010));
        advance();

        // store waits 3 cycles in MEM
        do_reset();
        set_id(1, T_S, 0, 2, 3, 0, 0, 1, 1); step();
        nop(); step();
        dmem_ready = 1'b0;
        repeat (3) begin
            sample();
            check("mw_exmem_en", 64'(exmem_en), 64'(0));
            check("mw_memwb_flush", 64'(memwb_flush), 64'(1));
            advance();
        end
        dmem_ready = 1'b1;
        sample();
        check("mw_release", 64'(exmem_en), 64'(1));
        check("mw_cnt", 64'(stall_cnt), 64'(3));
        advance();

        // redirect coincident with load-use
        do_reset();
        set_id(1, T_I, 5, 2, 0, 1, 1, 0, 1); step();
        set_id(1, T_R, 6, 5, 1, 1, 0, 0, 1); ex_redirect = 1'b1;
        sample();
        check("rl_flush", 64'({ifid_flush, idex_flush, pc_en}), 64'(3'b111));
        advance();
        ex_redirect = 1'b0; nop();
        sample();
        check("rl_cnt", 64'(stall_cnt), 64'(0));
        advance();

        // redirect held during a 2-cycle memory wait
        do_reset();
        set_id(1, T_I, 5, 2, 0, 1, 1, 0, 1); step();
        nop(); step();
        dmem_ready = 1'b0; ex_redirect = 1'b1;
        repeat (2) begin
            sample();
            check("rm_no_flush", 64'({ifid_flush, idex_flush}), 64'(2'b00));
            advance();
        end
        dmem_ready = 1'b1;
        sample();
        check("rm_flush", 64'({ifid_flush, idex_flush}), 64'(2'b11));
        advance();
        ex_redirect = 1'b0;

        // x0 never forwards; illegal pulse; reset during a memory wait
        do_reset();
        set_id(1, T_R, 0, 1, 2, 1, 0, 0, 1); step();
        set_id(1, T_R, 9, 0, 0, 1, 0, 0, 1); step();
        nop(); sample();
        check("x0_fwd", 64'(fwd_a), 64'(2'b00));
        advance();
        set_id(1, T_R, 5, 1, 2, 1, 0, 0, 0); step();
        nop(); sample();
        check("illegal_pulse", 64'(illegal_instr), 64'(1));
        advance();
        sample();
        check("illegal_clear", 64'(illegal_instr), 64'(0));
        advance();
        set_id(1, T_S, 0, 2, 3, 0, 0, 1, 1); step();
        nop(); step();
        dmem_ready = 1'b0; step();
        reset = 1'b1; step();
        reset = 1'b0;
        sample();
        check("rst_stall_en", 64'({pc_en, ifid_en, idex_en, exmem_en}), 64'(4'hF));
        advance();
        dmem_ready = 1'b1;

        // counter saturation
        do_reset();
        set_id(1, T_S, 0, 2, 3, 0, 0, 1, 1); step();
        nop(); step();
        dmem_ready = 1'b0;
        repeat (20) step();
        sample();
        check("cnt_sat", 64'(stall_cnt), 64'((1 << CNT_W) - 1));
        advance();
        dmem_ready = 1'b1;

        // randomized traffic
        do_reset();
        repeat (3000) begin
            int kind;
            reset = ($urandom_range(0, 63) == 0);
            kind  = $urandom_range(0, 3);
            set_id($urandom_range(0, 3) != 0, 7'(7'b1 << $urandom_range(0, 6)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   kind != 1 && $urandom_range(0, 3) != 0, kind == 0, kind == 1,
                   $urandom_range(0, 15) != 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            dmem_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
